// File: rtl/stage_sequencer.sv
// Top-level sequencer: steps through NUM_STAGES sub-FSMs with a
// begin/done handshake, then drains each stage's result to the UART.
module stage_sequencer #(
  parameter int NUM_STAGES    = 4,
  parameter int WAIT_WIDTH    = 13,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int SEL_WIDTH     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WAIT_WIDTH-1:0] wait_len,
  output logic [NUM_STAGES-1:0] begin_stage,
  input  logic [NUM_STAGES-1:0] done_stage,
  output logic [SEL_WIDTH-1:0]  uartsel,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [SEL_WIDTH-1:0]  err_stage
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    WAIT_UART,
    FINISH,
    ERROR
  } state_t;

  localparam logic [SEL_WIDTH-1:0] LAST =
    SEL_WIDTH'(NUM_STAGES - 1);

  state_t                   state;
  logic [SEL_WIDTH-1:0]     idx;
  logic [SEL_WIDTH-1:0]     err_q;
  logic [TIMEOUT_WIDTH-1:0] tcount;
  logic [WAIT_WIDTH-1:0]    wcount;
  logic [WAIT_WIDTH-1:0]    wait_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      err_q  <= '0;
      tcount <= '0;
      wcount <= '0;
      wait_q <= '0;
    end else if (abort) begin
      state <= IDLE;
      idx   <= '0;
      err_q <= '0;
    end else begin
      unique case (state)
        IDLE, FINISH: begin
          if (start) begin
            state  <= START;
            idx    <= '0;
            wait_q <= wait_len;
          end
        end
        START: begin
          state  <= WAIT_DONE;
          tcount <= '0;
        end
        WAIT_DONE: begin
          // A completion in the timeout cycle still counts
          if (done_stage[idx]) begin
            state  <= WAIT_UART;
            wcount <= '0;
          end else if (&tcount) begin
            state <= ERROR;
            err_q <= idx;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        WAIT_UART: begin
          if (wcount == wait_q) begin
            if (idx == LAST) begin
              state <= FINISH;
            end else begin
              state <= START;
              idx   <= idx + 1'b1;
            end
          end else begin
            wcount <= wcount + 1'b1;
          end
        end
        ERROR: state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

  assign begin_stage = (state == START) ?
    (NUM_STAGES'(1) << idx) : '0;
  assign uartsel = (state == WAIT_UART) ?
    (idx + 1'b1) : '0;
  assign busy = (state == START) ||
    (state == WAIT_DONE) || (state == WAIT_UART);
  assign done      = (state == FINISH);
  assign error     = (state == ERROR);
  assign err_stage = err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed and randomized
// runs checked against a per-stage timeline model.
module tb_stage_sequencer;

  localparam int NS = 4;
  localparam int WW = 13;
  localparam int TW = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [WW-1:0] wait_len;
  logic [NS-1:0] begin_stage;
  logic [NS-1:0] done_stage;
  logic [SW-1:0] uartsel;
  logic          busy;
  logic          done;
  logic          error;
  logic [SW-1:0] err_stage;

  int tests = 0;
  int fails = 0;

  stage_sequencer #(
    .NUM_STAGES(NS),
    .WAIT_WIDTH(WW),
    .TIMEOUT_WIDTH(TW),
    .SEL_WIDTH(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .wait_len(wait_len),
    .begin_stage(begin_stage),
    .done_stage(done_stage),
    .uartsel(uartsel),
    .busy(busy),
    .done(done),
    .error(error),
    .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_begin"}, 32'(begin_stage), 0);
    chk({tag, "_uartsel"}, 32'(uartsel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  // Leaves the bench at the negedge where START of stage 0 is visible.
  task automatic kick(input int wl);
    start    = 1'b1;
    wait_len = WW'(wl);
    step();
    start    = 1'b0;
    wait_len = WW'($urandom);
  endtask

  // Timeline of one stage: 1 begin cycle, d+1 WAIT_DONE cycles with
  // done_stage[i] raised on the last, wl+1 drain cycles.
  task automatic run_stage(input int i, input int wl,
                           input int d, input logic [NS-1:0] noise,
                           input bit last);
    logic [NS-1:0] bit_i;
    bit_i = NS'(1) << i;
    chk("start_begin", 32'(begin_stage), 32'(bit_i));
    chk("start_busy", 32'(busy), 1);
    chk("start_uartsel", 32'(uartsel), 0);
    done_stage = noise & ~bit_i;
    for (int k = 0; k <= d; k++) begin
      step();
      chk("wd_begin", 32'(begin_stage), 0);
      chk("wd_uartsel", 32'(uartsel), 0);
      chk("wd_busy", 32'(busy), 1);
      if (k == d) done_stage = bit_i | noise;
    end
    for (int c = 0; c <= wl; c++) begin
      step();
      if (c == 0) done_stage = '0;
      chk("wu_uartsel", 32'(uartsel), 32'(i + 1));
      chk("wu_busy", 32'(busy), 1);
      chk("wu_begin", 32'(begin_stage), 0);
    end
    step();
    if (last) begin
      chk("fin_done", 32'(done), 1);
      chk("fin_uartsel", 32'(uartsel), 0);
      chk("fin_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    int wl;
    reset      = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    wait_len   = '0;
    done_stage = '0;

    // reset held with start asserted
    step();
    step();
    chk_idle("rst");
    chk("rst_err_stage", 32'(err_stage), 0);
    reset = 1'b1;
    kick(3);
    chk("rst_first_begin", 32'(begin_stage), 32'h1);
    chk("rst_first_busy", 32'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_start");

    // full run, wait_len=3, done 5 cycles after begin
    kick(3);
    for (int i = 0; i < NS; i++)
      run_stage(i, 3, 4, '0, i == NS - 1);
    step();
    chk("finish_hold_done", 32'(done), 1);
    chk("finish_hold_begin", 32'(begin_stage), 0);

    // restart from FINISH with a 1-cycle drain; stage 2 answers on
    // the timeout cycle itself
    kick(0);
    for (int i = 0; i < NS; i++)
      run_stage(i, 0, (i == 2) ? 15 : i, '0, i == NS - 1);

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      wl = $urandom_range(0, 6);
      kick(wl);
      for (int i = 0; i < NS; i++)
        run_stage(i, wl, $urandom_range(0, 15),
                  NS'($urandom), i == NS - 1);
    end

    // maximum drain length
    kick(8191);
    run_stage(0, 8191, 2, '0, 1'b0);
    chk("maxdrain_next_begin", 32'(begin_stage), 32'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("maxdrain_abort");

    // timeout on stage 1
    kick(0);
    run_stage(0, 0, 1, '0, 1'b0);
    chk("to_begin1", 32'(begin_stage), 32'h2);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("to_wait_error", 32'(error), 0);
      chk("to_wait_busy", 32'(busy), 1);
    end
    step();
    chk("to_error", 32'(error), 1);
    chk("to_err_stage", 32'(err_stage), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_done", 32'(done), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_error_held", 32'(error), 1);
    chk("to_start_ignored", 32'(begin_stage), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("to_abort");

    // reset during WAIT_UART of stage 2
    kick(2);
    run_stage(0, 2, 1, '0, 1'b0);
    run_stage(1, 2, 1, '0, 1'b0);
    chk("mid_begin2", 32'(begin_stage), 32'h4);
    step();
    done_stage = 4'b0100;
    step();
    done_stage = '0;
    chk("mid_uartsel3", 32'(uartsel), 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_idle("mid_reset");

    // abort in WAIT_DONE; a foreign done bit must be ignored
    kick(1);
    chk("ab_begin0", 32'(begin_stage), 32'h1);
    done_stage = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab_wd_busy", 32'(busy), 1);
      chk("ab_wd_uartsel", 32'(uartsel), 0);
    end
    abort = 1'b1;
    step();
    abort      = 1'b0;
    done_stage = '0;
    chk_idle("ab_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised top-level sequencer that runs NUM_STAGES sub-FSMs in order using a begin/done handshake per stage.
- After each stage completes, it holds for a programmable UART drain interval, with uartsel routing that stage's result to the UART.
- Adds per-stage timeout, error reporting, abort and restart-from-finish.
- Sits above the per-stage FSMs and drives the UART output mux.

Parameters:
NUM_STAGES, 4, number of sequenced sub-FSMs (1..7)
WAIT_WIDTH, 13, width of UART drain counter and wait_len
TIMEOUT_WIDTH, 16, width of per-stage timeout counter
SEL_WIDTH, 3, width of uartsel/err_stage; must satisfy 2^SEL_WIDTH > NUM_STAGES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  begin sequence (sampled in IDLE and FINISH)
abort  input  1  synchronous abort to IDLE
wait_len  input  WAIT_WIDTH  UART drain length, latched when a sequence starts
begin_stage  output  NUM_STAGES  one-hot, single-cycle begin pulse to stage i
done_stage  input  NUM_STAGES  completion from stage i (level or pulse)
uartsel  output  SEL_WIDTH  UART mux select: 0 = idle, i+1 = stage i
busy  output  1  high in START, WAIT_DONE, WAIT_UART
done  output  1  high in FINISH
error  output  1  high in ERROR
err_stage  output  SEL_WIDTH  index of the timed-out stage, valid while error=1

Behaviour:
- All state is registered on the rising edge of clk. reset=0 at an edge forces IDLE and clears idx, counters and wait_q.
- Outputs after reset: begin_stage=0, uartsel=0, busy=0, done=0, error=0, err_stage=0.
- Priority at each edge: reset, then abort (any state -> IDLE, idx cleared), then the normal transitions below.
- States: IDLE, START, WAIT_DONE, WAIT_UART, FINISH, ERROR. All outputs are Moore (decoded from state/idx).
- IDLE:
  - start=1 -> START with idx=0; wait_q <= wait_len.
  - Otherwise stay in IDLE.
- START:
  - begin_stage[idx]=1 for exactly this one cycle.
  - Always -> WAIT_DONE; tcount <= 0.
- WAIT_DONE:
  - Only done_stage[idx] is sampled; other bits are ignored.
  - done_stage[idx]=1 -> WAIT_UART; wcount <= 0.
  - Else if tcount == all-ones -> ERROR; err_stage <= idx.
  - Else tcount++.
  - done_stage[idx] and timeout in the same cycle: done wins.
- WAIT_UART:
  - uartsel = idx+1.
  - wcount == wait_q -> if idx == NUM_STAGES-1 then FINISH, else idx++ and START.
  - Otherwise wcount++.
  - The state lasts exactly wait_q+1 cycles; wait_q=0 gives a 1-cycle drain.
- FINISH:
  - done=1, held.
  - start=1 -> START with idx=0; wait_q re-latched.
- ERROR:
  - error=1, held.
  - Exits only on reset or abort.
- Latency:
  - start edge to begin_stage[0] high: 1 cycle.
  - done_stage[idx] edge to WAIT_UART: 1 cycle.
  - Final WAIT_UART cycle to done=1: next edge.
- Counters never wrap in normal operation: the exit comparisons fire before overflow.
- wait_len changes mid-sequence have no effect until the next start.
- done_stage held high from a previous run is harmless: it is sampled only in WAIT_DONE, after the new begin pulse.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> state IDLE, all outputs 0. Release reset, start=1 for 1 cycle -> next cycle begin_stage=4'b0001, busy=1.
- Full run (NUM_STAGES=4, wait_len=3): pulse done_stage[i] 5 cycles after each begin -> each WAIT_UART lasts 4 cycles with uartsel=1,2,3,4 in turn. Begin pulses appear as 0001, 0010, 0100, 1000. done=1 after stage 3; uartsel=0 in FINISH.
- Max drain: wait_len=13'h1FFF -> WAIT_UART lasts 8192 cycles, then START of the next stage.
- Timeout: TIMEOUT_WIDTH=4, withhold done_stage[1] -> ERROR 16 cycles after entering WAIT_DONE for stage 1; error=1, err_stage=1. abort=1 -> IDLE next cycle.
- Reset/abort mid-operation: reset=0 during WAIT_UART of stage 2 -> IDLE, uartsel=0. Repeat with abort=1 in WAIT_DONE -> IDLE. done_stage[2]=1 while stage 0 is waiting -> ignored.
- Restart: in FINISH, start=1 with wait_len=0 -> begin_stage=0001 next cycle. Each WAIT_UART lasts 1 cycle; done=1 again at the end.
